// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit, one result bit per cycle.
//   MULT/MULTU produce the full 2*WIDTH product as {result_hi,result_lo}.
//   DIV/DIVU produce quotient in result_lo and remainder in result_hi.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b    multiplicand/dividend, multiplier/divisor
//   annul           cancel the in-flight operation
//   busy            unit is not idle
//   stallreq        pipeline stall request (accepting cycle and CALC)
//   done            one-cycle result-valid pulse
//   result_hi/lo    product halves or remainder/quotient
//   div_by_zero     last completed operation divided by zero
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             annul,
    output logic             busy,
    output logic             stallreq,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;          // negate product / quotient
    logic              rem_neg_q, rem_neg_d;  // negate remainder (dividend sign)
    logic [WIDTH-1:0]  hi_q, hi_d;            // partial product high / remainder
    logic [WIDTH-1:0]  lo_q, lo_d;            // multiplier / dividend-quotient
    logic [WIDTH-1:0]  b_q, b_d;              // multiplicand / divisor magnitude
    logic [WIDTH-1:0]  res_hi_q, res_hi_d;
    logic [WIDTH-1:0]  res_lo_q, res_lo_d;
    logic              dbz_q, dbz_d;

    logic              accept;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic              div_ge;
    logic [WIDTH-1:0]  step_hi, step_lo;
    logic [W2-1:0]     prod, prod_neg;
    logic [WIDTH-1:0]  fin_hi, fin_lo;

    assign accept = (state_q == S_IDLE) && start && !annul;

    // Operand magnitudes; op[0]==0 selects the signed variants
    always_comb begin : operand_prep
        a_neg = !op[0] && src_a[WIDTH-1];
        b_neg = !op[0] && src_b[WIDTH-1];
        a_mag = a_neg ? ({WIDTH{1'b0}} - src_a) : src_a;
        b_mag = b_neg ? ({WIDTH{1'b0}} - src_b) : src_b;
    end

    // One iteration of shift-add multiply or restoring divide, plus sign fix-up
    always_comb begin : iterate
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        // remainder < divisor keeps the shifted value below 2*divisor, so bit WIDTH is the borrow
        div_ge    = !div_diff[WIDTH];
        if (is_div_q) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_neg = {W2{1'b0}} - prod;
        if (is_div_q) begin
            fin_hi = rem_neg_q ? ({WIDTH{1'b0}} - step_hi) : step_hi;
            fin_lo = neg_q     ? ({WIDTH{1'b0}} - step_lo) : step_lo;
        end else begin
            fin_hi = neg_q ? prod_neg[W2-1:WIDTH]  : step_hi;
            fin_lo = neg_q ? prod_neg[WIDTH-1:0]   : step_lo;
        end
    end

    // Next-state and datapath update
    always_comb begin : next_state
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op[1] && (src_b == {WIDTH{1'b0}})) begin
                        state_d  = S_DONE;
                        res_hi_d = src_a;
                        res_lo_d = {WIDTH{1'b1}};
                        dbz_d    = 1'b1;
                    end else begin
                        state_d   = S_CALC;
                        cnt_d     = {CW{1'b0}};
                        is_div_d  = op[1];
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        hi_d      = {WIDTH{1'b0}};
                        lo_d      = a_mag;
                        b_d       = b_mag;
                    end
                end
            end
            S_CALC: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = S_DONE;
                        res_hi_d = fin_hi;
                        res_lo_d = fin_lo;
                        dbz_d    = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            res_hi_q  <= {WIDTH{1'b0}};
            res_lo_q  <= {WIDTH{1'b0}};
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign stallreq    = accept || (state_q == S_CALC);
    assign result_hi   = res_hi_q;
    assign result_lo   = res_lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit (WIDTH=32)
// against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         annul;
    logic         busy;
    logic         stallreq;
    logic         done;
    logic [W-1:0] result_hi;
    logic [W-1:0] result_lo;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] last_hi, last_lo;
    logic         last_dbz;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .annul       (annul),
        .busy        (busy),
        .stallreq    (stallreq),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed results via 64-bit signed arithmetic (truncating division,
    // remainder follows the dividend), unsigned via 64-bit unsigned arithmetic.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        dbz = 1'b0;
        sa  = $signed(a);
        sb  = $signed(b);
        case (o)
            2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = 64'(a) * 64'(b); hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == '0) begin
                    hi = a; lo = '1; dbz = 1'b1;
                end else if (o == 2'b11) begin
                    lo = a / b; hi = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    lo = 32'(q); hi = 32'(r);
                end
            end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ehi, elo;
        logic         edbz;
        int           lat, stl, exp_lat;
        bit           seen;
        model(o, a, b, ehi, elo, edbz);
        exp_lat = edbz ? 1 : W + 1;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        check({tag, " stall_accept"}, 64'(stallreq), 64'(1));
        check({tag, " idle_busy"},   64'(busy),     64'(0));
        stl = 1; lat = 0; seen = 1'b0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            lat++;
            if (done) seen = 1'b1;
            else if (stallreq) stl++;
        end
        check({tag, " done_seen"}, 64'(seen), 64'(1));
        check({tag, " latency"},   64'(lat),  64'(exp_lat));
        check({tag, " stall_len"}, 64'(stl),  64'(exp_lat));
        check({tag, " done_stall"}, 64'(stallreq), 64'(0));
        check({tag, " hi"},  64'(result_hi),   64'(ehi));
        check({tag, " lo"},  64'(result_lo),   64'(elo));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(edbz));
        @(negedge clk);
        #1;
        check({tag, " done_pulse"}, 64'(done), 64'(0));
        check({tag, " busy_after"}, 64'(busy), 64'(0));
        last_hi = ehi; last_lo = elo; last_dbz = edbz;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},  64'(busy),        64'(0));
        check({tag, " done"},  64'(done),        64'(0));
        check({tag, " stall"}, 64'(stallreq),    64'(0));
        check({tag, " hi"},    64'(result_hi),   64'(0));
        check({tag, " lo"},    64'(result_lo),   64'(0));
        check({tag, " dbz"},   64'(div_by_zero), 64'(0));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   ro;
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; annul = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Directed corner cases
        run_op("div_neg7_2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_neg7_2 lo_const", 64'(result_lo), 64'h0000_0000_FFFF_FFFD);
        check("div_neg7_2 hi_const", 64'(result_hi), 64'h0000_0000_FFFF_FFFF);
        run_op("divu_big",     2'b11, 32'hFFFF_FFFF, 32'h0000_0010);
        run_op("div_wrap",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_wrap lo_const", 64'(result_lo), 64'h0000_0000_8000_0000);
        run_op("mult_m1x2",    2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("multu_m1x2",   2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        check("multu_m1x2 hi_const", 64'(result_hi), 64'h1);
        run_op("divu_zero",    2'b11, 32'h0000_1234, 32'h0000_0000);
        run_op("div_zero",     2'b10, 32'h8000_0001, 32'h0000_0000);
        run_op("mult_minmin",  2'b00, 32'h8000_0000, 32'h8000_0000);
        run_op("div_7_neg2",   2'b10, 32'h0000_0007, 32'hFFFF_FFFE);

        // Random operations
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op("rand", ro, ra, rb);
        end

        // Annul five cycles into CALC: no done, results untouched, immediate restart
        run_op("pre_annul", 2'b01, 32'h0000_0003, 32'h0000_0005);
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'h0001_0000; src_b = 32'h0000_0003;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check("annul calc_busy", 64'(busy), 64'(1));
            check("annul calc_done", 64'(done), 64'(0));
        end
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        #1;
        check("annul busy",  64'(busy),        64'(0));
        check("annul done",  64'(done),        64'(0));
        check("annul hi",    64'(result_hi),   64'(last_hi));
        check("annul lo",    64'(result_lo),   64'(last_lo));
        check("annul dbz",   64'(div_by_zero), 64'(last_dbz));
        run_op("post_annul", 2'b00, 32'hFFFF_FFF0, 32'h0000_0007);

        // Annul in IDLE blocks a simultaneous start
        @(negedge clk);
        start = 1'b1; annul = 1'b1; op = 2'b01; src_a = 32'h5; src_b = 32'h6;
        #1;
        check("idle_annul stall", 64'(stallreq), 64'(0));
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        check("idle_annul busy", 64'(busy), 64'(0));

        // Reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("midcalc busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("midcalc_rst");
        rst = 1'b0;
        run_op("post_rst", 2'b10, 32'hFFFF_FF00, 32'h0000_0009);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
